vend_controller: RTL

Transaction sequencer for the vending datapath: accumulates credit from edge-detected nickel, dime and quarter inputs, then issues a dispense handshake to the product mechanism, then pays out change as a stream of single-coin handshakes. Cancel and inactivity timeout refund the full credit through the same payout path. It sits between the coin-acceptor inputs and the dispenser/hopper actuators, and drives the credit display.

---
 rtl/vend_pkg.sv | 40 ++++
 rtl/vend_if.sv | 23 ++
 rtl/vend_coin_edge.sv | 53 +++++
 rtl/vend_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin codes and coin values for the vending controller
package vend_pkg;

    localparam int CREDIT_W = 7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_PAYOUT  = 2'd3
    } state_t;

    // Payout coin codes driven to the hopper
    localparam logic [1:0] COIN_NONE    = 2'b00;
    localparam logic [1:0] COIN_NICKEL  = 2'b01;
    localparam logic [1:0] COIN_DIME    = 2'b10;
    localparam logic [1:0] COIN_QUARTER = 2'b11;

    // Coin values in cents
    localparam logic [CREDIT_W-1:0] NICKEL  = 7'd5;
    localparam logic [CREDIT_W-1:0] DIME    = 7'd10;
    localparam logic [CREDIT_W-1:0] QUARTER = 7'd25;

    // Largest coin that does not exceed the remaining amount
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] amount);
        if (amount >= QUARTER)   return COIN_QUARTER;
        else if (amount >= DIME) return COIN_DIME;
        else                     return COIN_NICKEL;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_NICKEL:  return NICKEL;
            COIN_DIME:    return DIME;
            COIN_QUARTER: return QUARTER;
            default:      return '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - dispense and payout handshakes between controller and actuators
//   dispense_req  controller -> dispenser   request product release
//   dispense_ack  dispenser  -> controller  product released
//   payout_valid  controller -> hopper      coin payout request
//   payout_coin   controller -> hopper      coin code (01 nickel, 10 dime, 11 quarter)
//   payout_ready  hopper     -> controller  coin accepted
interface vend_if;
    logic       dispense_req;
    logic       dispense_ack;
    logic       payout_valid;
    logic [1:0] payout_coin;
    logic       payout_ready;

    modport master (
        output dispense_req, payout_valid, payout_coin,
        input  dispense_ack, payout_ready
    );

    modport slave (
        input  dispense_req, payout_valid, payout_coin,
        output dispense_ack, payout_ready
    );
endinterface

// File: rtl/vend_coin_edge.sv
// rtl/vend_coin_edge.sv - enable-gated coin edge detect, priority select and reject pulse
//   clk, reset           clock, asynchronous active-low reset
//   enable               sample tick; prev bits only advance on a tick
//   nickel/dime/quarter  raw coin-detect levels
//   accept_en            controller can take a coin this tick
//   coin_oh              one-hot accepted coin {quarter, dime, nickel}, valid on the tick
//   coin_reject          registered one-cycle pulse when any edge was dropped
module coin_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       accept_en,
    output logic [2:0] coin_oh,
    output logic       coin_reject
);
    logic       n_prev_q, d_prev_q, q_prev_q;
    logic       coin_reject_q;
    logic [2:0] edges_w;

    assign edges_w = {quarter & ~q_prev_q, dime & ~d_prev_q, nickel & ~n_prev_q} & {3{enable}};

    // Nickel beats dime beats quarter; everything is dropped when not accepting
    always_comb begin
        coin_oh = 3'b000;
        if (accept_en) begin
            if (edges_w[0])      coin_oh = 3'b001;
            else if (edges_w[1]) coin_oh = 3'b010;
            else if (edges_w[2]) coin_oh = 3'b100;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_prev_q      <= 1'b0;
            d_prev_q      <= 1'b0;
            q_prev_q      <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            if (enable) begin
                n_prev_q <= nickel;
                d_prev_q <= dime;
                q_prev_q <= quarter;
            end
            // Several dropped edges on one tick still give a single pulse
            coin_reject_q <= |(edges_w & ~coin_oh);
        end
    end

    assign coin_reject = coin_reject_q;
endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - credit collection, dispense handshake and greedy change payout
//   clk, reset           clock, asynchronous active-low reset
//   enable               sample tick for coins, cancel and the inactivity timer
//   nickel/dime/quarter  raw coin-detect levels (rising edge = coin)
//   cancel               refund request, sampled on ticks in COLLECT
//   bus                  dispense and payout handshakes (master side)
//   credit               current credit or remaining payout in cents
//   busy                 high whenever not IDLE
//   coin_reject          one-cycle pulse per tick with dropped coin edges
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE   = 55,
    parameter int TIMEOUT = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    vend_if.master              bus,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject
);
    localparam int                  TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                dispense_req_q;
    logic                payout_valid_q;

    logic [2:0]          coin_oh;
    logic                coin_acc_w;
    logic [CREDIT_W-1:0] coin_val_w;
    logic [CREDIT_W-1:0] sum_w;
    logic [CREDIT_W-1:0] change_w;
    logic [1:0]          pay_coin_w;
    logic [CREDIT_W-1:0] left_w;

    coin_edge u_coin_edge (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .nickel      (nickel),
        .dime        (dime),
        .quarter     (quarter),
        .accept_en   ((state_q == S_IDLE) || (state_q == S_COLLECT)),
        .coin_oh     (coin_oh),
        .coin_reject (coin_reject)
    );

    always_comb begin
        coin_val_w = '0;
        case (coin_oh)
            3'b001:  coin_val_w = NICKEL;
            3'b010:  coin_val_w = DIME;
            3'b100:  coin_val_w = QUARTER;
            default: coin_val_w = '0;
        endcase
    end

    assign coin_acc_w = |coin_oh;
    assign sum_w      = credit_q + coin_val_w;
    assign change_w   = credit_q - PRICE_C;
    assign pay_coin_w = greedy_coin(credit_q);
    assign left_w     = credit_q - coin_value(pay_coin_w);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            tmo_q          <= '0;
            dispense_req_q <= 1'b0;
            payout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (coin_acc_w) begin
                        credit_q <= sum_w;
                        tmo_q    <= '0;
                        state_q  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (coin_acc_w) begin
                        credit_q <= sum_w;
                        tmo_q    <= '0;
                    end
                    // Reaching the price wins over a cancel on the same tick;
                    // otherwise the coin is folded into the refund.
                    if (coin_acc_w && (sum_w >= PRICE_C)) begin
                        state_q        <= S_VEND;
                        dispense_req_q <= 1'b1;
                    end else if (enable && (cancel || (!coin_acc_w && (tmo_q == TMO_LAST)))) begin
                        state_q        <= S_PAYOUT;
                        payout_valid_q <= 1'b1;
                        tmo_q          <= '0;
                    end else if (enable && !coin_acc_w) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_VEND: begin
                    if (bus.dispense_ack) begin
                        dispense_req_q <= 1'b0;
                        credit_q       <= change_w;
                        if (change_w != '0) begin
                            state_q        <= S_PAYOUT;
                            payout_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_PAYOUT: begin
                    if (bus.payout_ready) begin
                        credit_q <= left_w;
                        if (left_w == '0) begin
                            state_q        <= S_IDLE;
                            payout_valid_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.dispense_req = dispense_req_q;
    assign bus.payout_valid = payout_valid_q;
    // Coin code follows registered credit only, so it holds until accepted
    assign bus.payout_coin  = (state_q == S_PAYOUT) ? pay_coin_w : COIN_NONE;
    assign credit           = credit_q;
    assign busy             = (state_q != S_IDLE);
endmodule
